pe_seq_ctrl: RTL and testbench

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

---
 rtl/pe_seq_pkg.sv | 20 ++
 rtl/pe_result_fifo.sv | 64 ++++++
 rtl/pe_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types and default sizes for the PE sequencing controller and its result FIFO.
package pe_seq_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int CNT_W_DEF      = 8;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int PE_VEC_W       = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Bits needed to hold a credit count of 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// Synchronous 32-bit result FIFO; a push and a pop in the same cycle both take effect.
module pe_result_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head_data,
    output logic        not_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_empty = (occ != '0);
    assign full      = (occ == DEPTH_OCC);
    assign do_pop    = pop && not_empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; occ decides what is visible, so stale words are harmless.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequences buffer reads into a dot-product PE, gates last chunks on result-FIFO credit,
// and collects PE results in issue order.
module pe_seq_ctrl
    import pe_seq_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  vec_num,
    input  logic [CNT_W-1:0]  out_num,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] nbuf_addr,
    output logic [ADDR_W-1:0] wbuf_addr,
    output logic              buf_rd_en,
    output logic              pe_vld,
    output logic [1:0]        pe_ctl,
    input  logic              pe_vld_o,
    input  logic [31:0]       pe_result,
    output logic [31:0]       res_data,
    output logic              res_valid,
    input  logic              res_ready
);

    localparam int CRED_W = credit_width(FIFO_DEPTH);
    localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_e            state;
    state_e            next_state;
    logic [CNT_W-1:0]  vec_q;
    logic [CNT_W-1:0]  out_q;
    logic [CNT_W-1:0]  chunk;
    logic [CNT_W-1:0]  outer;
    logic [CNT_W-1:0]  rcv_cnt;
    logic [ADDR_W-1:0] wbuf_cnt;
    logic [CRED_W-1:0] credit;
    logic              accept;
    logic              zero_job;
    logic              last_chunk;
    logic              last_out;
    logic              issue;
    logic              pop;
    logic              final_rsp;
    logic              done_q;

    assign accept     = start && (state == IDLE);
    assign zero_job   = (vec_num == '0) || (out_num == '0);
    assign last_chunk = (chunk == vec_q - CNT_ONE);
    assign last_out   = (outer == out_q - CNT_ONE);
    assign pop        = res_valid && res_ready;
    assign final_rsp  = (state == DRAIN) && pe_vld_o && (rcv_cnt == out_q - CNT_ONE);

    // NOTE: state-holding blocks use <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults first, so no path through this block can infer a latch.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !zero_job) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                // Only a last chunk needs a FIFO slot reserved, so only it waits on credit.
                issue = !(last_chunk && (credit == '0));
                if (issue && last_chunk && last_out) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (done_q) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q    <= '0;
            out_q    <= '0;
            chunk    <= '0;
            outer    <= '0;
            rcv_cnt  <= '0;
            wbuf_cnt <= '0;
            pe_vld   <= 1'b0;
            pe_ctl   <= 2'b00;
            done_q   <= 1'b0;
        end else begin
            done_q <= (accept && zero_job) || (final_rsp && !done_q);
            pe_vld <= issue;
            pe_ctl <= issue ? {last_chunk, (chunk == '0)} : 2'b00;
            if (accept && !zero_job) begin
                vec_q    <= vec_num;
                out_q    <= out_num;
                chunk    <= '0;
                outer    <= '0;
                rcv_cnt  <= '0;
                wbuf_cnt <= '0;
            end else begin
                if (issue) begin
                    wbuf_cnt <= wbuf_cnt + ADDR_W'(1);
                    if (last_chunk) begin
                        chunk <= '0;
                        outer <= outer + CNT_ONE;
                    end else begin
                        chunk <= chunk + CNT_ONE;
                    end
                end
                if (pe_vld_o && (state != IDLE)) begin
                    rcv_cnt <= rcv_cnt + CNT_ONE;
                end
            end
        end
    end

    // Credit tracks free FIFO slots not yet promised to an in-flight dot product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= CRED_INIT;
        end else begin
            case ({issue && last_chunk, pop})
                2'b10:   credit <= credit - CRED_W'(1);
                2'b01:   credit <= credit + CRED_W'(1);
                default: credit <= credit;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign buf_rd_en = issue;
    assign nbuf_addr = ADDR_W'(chunk);
    assign wbuf_addr = wbuf_cnt;

    pe_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pe_vld_o),
        .push_data (pe_result),
        .pop       (res_ready),
        .head_data (res_data),
        .not_empty (res_valid)
    );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a behavioural buffer + PE model and per-cycle capture.
module tb_pe_seq_ctrl;

    localparam int AW = 16;
    localparam int CW = 8;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] vec_num = '0;
    logic [CW-1:0] out_num = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] nbuf_addr;
    logic [AW-1:0] wbuf_addr;
    logic          buf_rd_en;
    logic          pe_vld;
    logic [1:0]    pe_ctl;
    logic          pe_vld_o;
    logic [31:0]   pe_result;
    logic [31:0]   res_data;
    logic          res_valid;
    logic          res_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int overflows = 0;
    int occ = 0;
    int base = 0;
    logic [31:0] got [$];

    logic [31:0]   rd_m, vld_m, done_m, busy_m, rv_m;
    logic [1:0]    ctl_a [32];
    logic [AW-1:0] nb_a  [32];
    logic [AW-1:0] wb_a  [32];

    always #5 clk = ~clk;

    pe_seq_ctrl #(
        .ADDR_W     (AW),
        .CNT_W      (CW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_num   (vec_num),
        .out_num   (out_num),
        .busy      (busy),
        .done      (done),
        .nbuf_addr (nbuf_addr),
        .wbuf_addr (wbuf_addr),
        .buf_rd_en (buf_rd_en),
        .pe_vld    (pe_vld),
        .pe_ctl    (pe_ctl),
        .pe_vld_o  (pe_vld_o),
        .pe_result (pe_result),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    // Buffers return 16*wbuf_addr + nbuf_addr one cycle after the read; PE sums a
    // dot product's chunks and emits one cycle after its last chunk.
    logic [31:0] rd_data;
    logic [31:0] acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= '0;
            acc       <= '0;
            pe_vld_o  <= 1'b0;
            pe_result <= '0;
        end else begin
            if (buf_rd_en) rd_data <= (32'(wbuf_addr) << 4) + 32'(nbuf_addr);
            pe_vld_o <= pe_vld && pe_ctl[1];
            if (pe_vld) begin
                acc       <= (pe_ctl[0] ? 32'd0 : acc) + rd_data;
                pe_result <= (pe_ctl[0] ? 32'd0 : acc) + rd_data;
            end
        end
    end

    // Occupancy model of the result FIFO: records pops and flags any write into a full FIFO.
    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
        end else begin
            if (pe_vld_o && occ >= FD) begin
                overflows++;
                $display("FAIL fifo_overflow: write with occupancy %0d, limit %0d", occ, FD);
            end
            if (res_valid && res_ready) got.push_back(res_data);
            occ = occ + (pe_vld_o ? 1 : 0) - ((res_valid && res_ready) ? 1 : 0);
        end
    end

    // Pulses start (cycle 0) and records outputs for cycles 1..ncyc.
    task automatic run_job(input logic [CW-1:0] v, input logic [CW-1:0] o,
                           input int ready_from, input int restart_at, input int ncyc);
        base   = got.size();
        rd_m   = '0; vld_m = '0; done_m = '0; busy_m = '0; rv_m = '0;
        vec_num   = v;
        out_num   = o;
        start     = 1'b1;
        res_ready = (ready_from <= 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            start = (c == restart_at);
            if (c == restart_at) begin
                vec_num = 8'd1;
                out_num = 8'd1;
            end
            res_ready = (c >= ready_from);
            #1;
            rd_m[c]   = buf_rd_en;
            vld_m[c]  = pe_vld;
            done_m[c] = done;
            busy_m[c] = busy;
            rv_m[c]   = res_valid;
            ctl_a[c]  = pe_ctl;
            nb_a[c]   = nbuf_addr;
            wb_a[c]   = wbuf_addr;
        end
        start     = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, buf_rd_en, pe_vld, pe_ctl, res_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {busy, done, buf_rd_en, pe_vld, pe_ctl, res_valid});
        end
        vectors++;
        if (nbuf_addr !== 16'd0 || wbuf_addr !== 16'd0 || dut.credit !== 2'd2) begin
            miscompares++;
            $display("FAIL reset_counters: got nbuf=%0d wbuf=%0d credit=%0d expected 0 0 2",
                     nbuf_addr, wbuf_addr, dut.credit);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [1:0] exp_ctl [9];
        exp_ctl = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
        run_job(8'd3, 8'd2, 0, -1, 12);
        vectors++;
        if (rd_m !== 32'h0000_007e) begin
            miscompares++;
            $display("FAIL basic_rd_en: got %h expected %h", rd_m, 32'h0000_007e);
        end
        vectors++;
        if (vld_m !== 32'h0000_00fc) begin
            miscompares++;
            $display("FAIL basic_pe_vld: got %h expected %h", vld_m, 32'h0000_00fc);
        end
        vectors++;
        if (done_m !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL basic_done: got %h expected %h", done_m, 32'h0000_0200);
        end
        vectors++;
        if (busy_m !== 32'h0000_03fe) begin
            miscompares++;
            $display("FAIL basic_busy: got %h expected %h", busy_m, 32'h0000_03fe);
        end
        vectors++;
        if (rv_m !== 32'h0000_0240) begin
            miscompares++;
            $display("FAIL basic_res_valid: got %h expected %h", rv_m, 32'h0000_0240);
        end
        for (int c = 1; c <= 8; c++) begin
            vectors++;
            if (ctl_a[c] !== exp_ctl[c]) begin
                miscompares++;
                $display("FAIL basic_pe_ctl cycle %0d: got %b expected %b", c, ctl_a[c], exp_ctl[c]);
            end
        end
        for (int c = 1; c <= 6; c++) begin
            vectors++;
            if (nb_a[c] !== 16'((c - 1) % 3) || wb_a[c] !== 16'(c - 1)) begin
                miscompares++;
                $display("FAIL basic_addr cycle %0d: got n=%0d w=%0d expected n=%0d w=%0d",
                         c, nb_a[c], wb_a[c], (c - 1) % 3, c - 1);
            end
        end
        vectors++;
        if (got.size() !== base + 2 || got[base] !== 32'd51 || got[base + 1] !== 32'd195) begin
            miscompares++;
            $display("FAIL basic_results: got %0d results expected 2 (51,195)", got.size() - base);
        end
    endtask

    task automatic test_single_chunk();
        run_job(8'd1, 8'd4, 0, -1, 12);
        vectors++;
        if (rd_m !== 32'h0000_0066) begin
            miscompares++;
            $display("FAIL single_rd_en: got %h expected %h", rd_m, 32'h0000_0066);
        end
        vectors++;
        if (vld_m !== 32'h0000_00cc) begin
            miscompares++;
            $display("FAIL single_pe_vld: got %h expected %h", vld_m, 32'h0000_00cc);
        end
        vectors++;
        if (rv_m !== 32'h0000_0330) begin
            miscompares++;
            $display("FAIL single_res_valid: got %h expected %h", rv_m, 32'h0000_0330);
        end
        vectors++;
        if (done_m !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL single_done: got %h expected %h", done_m, 32'h0000_0200);
        end
        for (int c = 1; c <= 12; c++) begin
            vectors++;
            if (ctl_a[c] !== (vld_m[c] ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("FAIL single_pe_ctl cycle %0d: got %b expected %b",
                         c, ctl_a[c], vld_m[c] ? 2'b11 : 2'b00);
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got.size() <= base + i || got[base + i] !== 32'(16 * i)) begin
                miscompares++;
                $display("FAIL single_result %0d: got %0d results expected value %0d", i, got.size() - base, 16 * i);
            end
        end
    endtask

    // Shared by the backpressure test and the post-reset job.
    task automatic check_backpressure(input string tag);
        run_job(8'd1, 8'd4, 8, -1, 16);
        vectors++;
        if (rd_m !== 32'h0000_0606) begin
            miscompares++;
            $display("FAIL %s_rd_en: got %h expected %h", tag, rd_m, 32'h0000_0606);
        end
        vectors++;
        if (vld_m !== 32'h0000_0c0c) begin
            miscompares++;
            $display("FAIL %s_pe_vld: got %h expected %h", tag, vld_m, 32'h0000_0c0c);
        end
        vectors++;
        if (rv_m !== 32'h0000_33f0) begin
            miscompares++;
            $display("FAIL %s_res_valid: got %h expected %h", tag, rv_m, 32'h0000_33f0);
        end
        vectors++;
        if (done_m !== 32'h0000_2000 || busy_m !== 32'h0000_3ffe) begin
            miscompares++;
            $display("FAIL %s_done_busy: got %h/%h expected %h/%h", tag, done_m, busy_m,
                     32'h0000_2000, 32'h0000_3ffe);
        end
        vectors++;
        if (wb_a[9] !== 16'd2 || wb_a[10] !== 16'd3 || nb_a[9] !== 16'd0) begin
            miscompares++;
            $display("FAIL %s_held_addr: got w9=%0d w10=%0d n9=%0d expected 2 3 0",
                     tag, wb_a[9], wb_a[10], nb_a[9]);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got.size() <= base + i || got[base + i] !== 32'(16 * i)) begin
                miscompares++;
                $display("FAIL %s_result %0d: got %0d results expected value %0d", tag, i, got.size() - base, 16 * i);
            end
        end
    endtask

    task automatic test_zero_job();
        run_job(8'd3, 8'd0, 0, -1, 4);
        vectors++;
        if (done_m !== 32'h0000_0002 || busy_m !== 32'h0 || rd_m !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_out: got done=%h busy=%h rd=%h expected 00000002 0 0", done_m, busy_m, rd_m);
        end
        run_job(8'd0, 8'd2, 0, -1, 4);
        vectors++;
        if (done_m !== 32'h0000_0002 || busy_m !== 32'h0 || rd_m !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_vec: got done=%h busy=%h rd=%h expected 00000002 0 0", done_m, busy_m, rd_m);
        end
    endtask

    task automatic test_start_while_busy();
        run_job(8'd3, 8'd2, 0, 3, 12);
        vectors++;
        if (rd_m !== 32'h0000_007e || done_m !== 32'h0000_0200 || busy_m !== 32'h0000_03fe) begin
            miscompares++;
            $display("FAIL restart_masks: got rd=%h done=%h busy=%h expected 0000007e 00000200 000003fe",
                     rd_m, done_m, busy_m);
        end
        vectors++;
        if (wb_a[6] !== 16'd5 || nb_a[6] !== 16'd2 || ctl_a[7] !== 2'b10) begin
            miscompares++;
            $display("FAIL restart_counts: got w6=%0d n6=%0d ctl7=%b expected 5 2 10", wb_a[6], nb_a[6], ctl_a[7]);
        end
        vectors++;
        if (got.size() !== base + 2 || got[base] !== 32'd51 || got[base + 1] !== 32'd195) begin
            miscompares++;
            $display("FAIL restart_results: got %0d results expected 2 (51,195)", got.size() - base);
        end
    endtask

    task automatic test_reset_mid_job();
        vec_num   = 8'd4;
        out_num   = 8'd1;
        start     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (buf_rd_en !== 1'b1 || nbuf_addr !== 16'd1) begin
            miscompares++;
            $display("FAIL midrst_running: got rd=%b n=%0d expected 1 1", buf_rd_en, nbuf_addr);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, buf_rd_en, pe_vld, pe_ctl, res_valid} !== 7'b0 ||
            nbuf_addr !== 16'd0 || wbuf_addr !== 16'd0 || dut.credit !== 2'd2) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %b n=%0d w=%0d credit=%0d expected 0000000 0 0 2",
                     {busy, done, buf_rd_en, pe_vld, pe_ctl, res_valid}, nbuf_addr, wbuf_addr, dut.credit);
        end
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_quiet cycle %0d: got done=%b busy=%b rv=%b expected 0 0 0",
                         c, done, busy, res_valid);
            end
        end
        check_backpressure("postrst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_chunk();
        check_backpressure("backpressure");
        test_zero_job();
        test_start_while_busy();
        test_reset_mid_job();
        repeat (4) @(posedge clk);
        vectors++;
        if (overflows !== 0) begin
            miscompares++;
            $display("FAIL fifo_overflow_total: got %0d expected 0", overflows);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
